// File: rtl/jtkicker_colmix_pkg.sv
// jtkicker_colmix_pkg: palette format encodings and helpers shared by the colour mixer
package jtkicker_colmix_pkg;
   localparam int FMT_332 = 0;
   localparam int FMT_444 = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // 3-3-2 byte {B,G,R} to 4-4-4 word {B,G,R}, top bits replicated into the new LSBs
   function automatic logic [11:0] expand_332(input logic [7:0] d);
      return {d[7:6], d[7:6], d[5:3], d[5], d[2:0], d[2]};
   endfunction
endpackage

// File: rtl/jtkicker_colmix_prio.sv
// jtkicker_colmix_prio: per-pixel layer priority/transparency resolver, registers the palette address
module jtkicker_colmix_prio
   import jtkicker_colmix_pkg::*;
#(
   parameter int NL = 2,
   parameter int PW = 4,
   parameter int TW = 2,
   localparam int LW = clog2(NL),
   localparam int AW = LW + PW
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pxl_cen,
   input  logic [NL*PW-1:0] lyr_pxl,
   input  logic [NL-1:0]    gfx_en,
   input  logic             prio_swap,
   output logic [AW-1:0]    pal_addr
);
   logic [LW-1:0] win;
   logic [PW-1:0] wpxl;

   // scan position i maps to a layer; prio_swap exchanges only the first two
   function automatic int slot(input int i, input logic s);
      return (s && i < 2) ? 1 - i : i;
   endfunction

   // walk the scan order backwards so the earliest opaque layer is the last to win
   always_comb begin
      win  = LW'(NL-1);
      wpxl = gfx_en[NL-1] ? lyr_pxl[(NL-1)*PW +: PW] : '0;
      for (int i = NL-1; i >= 0; i--)
         if (gfx_en[slot(i, prio_swap)] && lyr_pxl[slot(i, prio_swap)*PW +: TW] != '0) begin
            win  = LW'(slot(i, prio_swap));
            wpxl = lyr_pxl[slot(i, prio_swap)*PW +: PW];
         end
   end

   // palette address is {winning layer, its pixel}
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pal_addr <= '0;
      else if (pxl_cen) pal_addr <= {win, wpxl};
endmodule

// File: rtl/jtkicker_colmix.sv
// jtkicker_colmix: N-layer priority mixer, palette lookup and blank-aligned RGB output.
// Optional JTKICKER_COLMIX_DIM_EN halves every gun when the pixel's dim flag is set.
module jtkicker_colmix
   import jtkicker_colmix_pkg::*;
#(
   parameter int NL        = 2,
   parameter int PW        = 4,
   parameter int TW        = 2,
   parameter int FMT       = 0,
   parameter int BLANK_DLY = 8,
   parameter     SIMFILE   = "",
   localparam int LW = clog2(NL),
   localparam int AW = LW + PW,
   localparam int DW = (FMT == FMT_444) ? 12 : 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pxl_cen,
   input  logic [NL*PW-1:0] lyr_pxl,
   input  logic [NL-1:0]    gfx_en,
   input  logic             prio_swap,
   input  logic             dim,
   input  logic             LHBL,
   input  logic             LVBL,
   input  logic [AW-1:0]    prog_addr,
   input  logic [DW-1:0]    prog_data,
   input  logic             prog_en,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue,
   output logic             LHBL_dly,
   output logic             LVBL_dly
);
   // palette contents arrive through prog_*; SIMFILE stays for drop-in compatibility
   localparam bit unused_simfile = SIMFILE != "";

   logic [AW-1:0]        pal_addr;
   logic [DW-1:0]        mem [2**AW];
   logic [DW-1:0]        pal_q;
   logic [11:0]          rgb_raw, rgb_mix;
   logic [11:0]          rgb_sr [BLANK_DLY-2];
   logic [BLANK_DLY-1:0] hb_sr, vb_sr;

   jtkicker_colmix_prio #(.NL(NL), .PW(PW), .TW(TW)) u_prio (
      .clk       (clk),
      .rst_n     (rst_n),
      .pxl_cen   (pxl_cen),
      .lyr_pxl   (lyr_pxl),
      .gfx_en    (gfx_en),
      .prio_swap (prio_swap),
      .pal_addr  (pal_addr)
   );

   // palette programming runs on every clk, independent of the pixel enable
   always_ff @(posedge clk)
      if (prog_en) mem[prog_addr] <= prog_data;

   // palette read; a write on the same clk is not yet visible here
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pal_q <= '0;
      else if (pxl_cen) pal_q <= mem[pal_addr];

   if (FMT == FMT_444) begin : g_444
      assign rgb_raw = pal_q;
   end else begin : g_332
      assign rgb_raw = expand_332(pal_q);
   end

`ifdef JTKICKER_COLMIX_DIM_EN
   logic [1:0] dim_sr;

   // dim follows its pixel through the priority and palette stages
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dim_sr <= '0;
      else if (pxl_cen) dim_sr <= {dim_sr[0], dim};

   assign rgb_mix = dim_sr[1] ? {1'b0, rgb_raw[11:9], 1'b0, rgb_raw[7:5], 1'b0, rgb_raw[3:1]} : rgb_raw;
`else
   logic unused_dim;
   assign unused_dim = dim;
   assign rgb_mix    = rgb_raw;
`endif

   // blanking delay line; its length sets the total pixel-to-output latency
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hb_sr <= '0;
         vb_sr <= '0;
      end else if (pxl_cen) begin
         hb_sr <= {hb_sr[BLANK_DLY-2:0], LHBL};
         vb_sr <= {vb_sr[BLANK_DLY-2:0], LVBL};
      end

   // RGB trails the blanking line by the two mixing stages so both land together
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rgb_sr <= '{default: '0};
      else if (pxl_cen) begin
         rgb_sr[0] <= rgb_mix;
         for (int i = 1; i < BLANK_DLY-2; i++) rgb_sr[i] <= rgb_sr[i-1];
      end

   assign LHBL_dly = hb_sr[BLANK_DLY-1];
   assign LVBL_dly = vb_sr[BLANK_DLY-1];
   assign {blue, green, red} = (LHBL_dly && LVBL_dly) ? rgb_sr[BLANK_DLY-3] : 12'd0;
endmodule

// File: tb/tb_jtkicker_colmix.sv
// tb_jtkicker_colmix: self-checking bench for the default NL=2, FMT=0, BLANK_DLY=8 build
module tb_jtkicker_colmix;
   localparam int D = 8;

   logic       clk = 0, rst_n = 0, pxl_cen = 0, prio_swap = 0, dim = 0;
   logic       LHBL = 1, LVBL = 1, prog_en = 0;
   logic [7:0] lyr_pxl = 0;
   logic [1:0] gfx_en = 2'b11;
   logic [4:0] prog_addr = 0;
   logic [7:0] prog_data = 0;
   logic [3:0] red, green, blue;
   logic       LHBL_dly, LVBL_dly;

   logic [7:0]  pal [32];
   logic [13:0] exp_q [$];
   int errors = 0, checks = 0, np = 0;

   always #5 clk = ~clk;

   jtkicker_colmix dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pxl_cen   (pxl_cen),
      .lyr_pxl   (lyr_pxl),
      .gfx_en    (gfx_en),
      .prio_swap (prio_swap),
      .dim       (dim),
      .LHBL      (LHBL),
      .LVBL      (LVBL),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_en   (prog_en),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .LHBL_dly  (LHBL_dly),
      .LVBL_dly  (LVBL_dly)
   );

   // expected {LHBL_dly, LVBL_dly, red, green, blue} for one input pixel
   function automatic logic [13:0] model(input logic [7:0] lp, input logic [1:0] en,
                                         input logic sw, input logic dm, input logic hb, input logic vb);
      int order [2];
      int w, p, d, r, g, b;
      order[0] = sw ? 1 : 0;
      order[1] = sw ? 0 : 1;
      w = -1;
      for (int j = 0; j < 2; j++)
         if (w < 0 && en[order[j]] && (lp >> (order[j]*4)) % 4 != 0) w = order[j];
      if (w < 0) begin
         w = 1;
         p = en[1] ? int'(lp) / 16 : 0;
      end else p = (int'(lp) >> (w*4)) % 16;
      d = int'(pal[w*16 + p]);
      r = (d % 8) * 2 + (d % 8) / 4;
      g = ((d / 8) % 8) * 2 + ((d / 8) % 8) / 4;
      b = (d / 64) * 5;
`ifdef JTKICKER_COLMIX_DIM_EN
      if (dm) begin
         r = r / 2;
         g = g / 2;
         b = b / 2;
      end
`else
      if (dm) r = r + 0;
`endif
      if (!(hb && vb)) begin
         r = 0;
         g = 0;
         b = 0;
      end
      return {hb, vb, 4'(r), 4'(g), 4'(b)};
   endfunction

   function automatic logic [13:0] cur_exp();
      return np >= D ? exp_q[np-D] : 14'd0;
   endfunction

   task automatic check(input string tag, input logic [13:0] expv);
      checks++;
      assert ({LHBL_dly, LVBL_dly, red, green, blue} === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, {LHBL_dly, LVBL_dly, red, green, blue}, expv);
      end
   endtask

   task automatic pal_wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      prog_addr = a;
      prog_data = d;
      prog_en   = 1;
      pal[a]    = d;
      @(negedge clk);
      prog_en = 0;
   endtask

   // one pixel: check the output held over the idle clock, then present and check
   task automatic step(input logic [7:0] lp, input logic [1:0] en, input logic sw,
                       input logic dm, input logic hb, input logic vb, input string tag);
      @(negedge clk);
      check({tag, "_hold"}, cur_exp());
      lyr_pxl   = lp;
      gfx_en    = en;
      prio_swap = sw;
      dim       = dm;
      LHBL      = hb;
      LVBL      = vb;
      pxl_cen   = 1;
      exp_q.push_back(model(lp, en, sw, dm, hb, vb));
      np++;
      @(negedge clk);
      pxl_cen = 0;
      check(tag, cur_exp());
   endtask

   task automatic rnd_step(input string tag);
      step(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0, tag);
   endtask

   initial begin
      #1 check("reset", 14'd0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      for (int a = 0; a < 32; a++) pal_wr(5'(a), 8'($urandom));
      pal_wr(5'h05, 8'hFF);
      pal_wr(5'h16, 8'h07);
      pal_wr(5'h10, 8'h5A);
      repeat (D) step(8'h35, 2'b11, 0, 0, 1, 1, "white");
      check("white_const", {2'b11, 12'hFFF});
      repeat (D) step(8'h64, 2'b11, 0, 0, 1, 1, "transp");
      check("transp_const", {2'b11, 12'hF00});
      repeat (D) step(8'h90, 2'b00, 0, 0, 1, 1, "bg");
      check("bg_const", {2'b11, 12'h465});
      repeat (4) step(8'h35, 2'b11, 1, 0, 1, 1, "swap");
      repeat (2) step(8'h35, 2'b11, 0, 0, 1, 1, "pre_hb");
      repeat (3) step(8'h35, 2'b11, 0, 0, 0, 1, "hblank");
      repeat (D) step(8'h35, 2'b11, 0, 0, 1, 1, "post_hb");
      for (int i = 0; i < 200; i++) rnd_step("rand");
      @(negedge clk);
      rst_n = 0;
      #1 check("midrst", 14'd0);
      @(negedge clk);
      rst_n = 1;
      exp_q.delete();
      np = 0;
      for (int i = 0; i < 40; i++) rnd_step("after_rst");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
